// File: rtl/i2c_eeprom_master.sv
// i2c_eeprom_master
// Single-master I2C controller for a 2048-byte EEPROM (24C16 style, with the
// three upper address bits carried in the control byte). It performs one
// single-byte write or one single-byte random read per request.
//
// Every bus bit slot is four quarters of CLK_DIV clocks:
//   Q0 SCL low, SDA updated / Q1 SCL high / Q2 SCL high, SDA sampled / Q3 SCL low
// A write takes 29 slots and a read 39 slots. done pulses in the FIN state,
// one cycle after the last slot ends.
//
// Ports
//   clk    in    system clock, rising edge
//   rst_n  in    asynchronous active-low reset
//   wr     in    write request (wins over rd), sampled while idle
//   rd     in    random-read request, sampled while idle
//   addr   in    11-bit byte address
//   wdata  in    write data
//   rdata  out   last byte read successfully
//   busy   out   transaction in progress
//   done   out   one-cycle end-of-transaction pulse
//   nack   out   slave failed to acknowledge (valid with done)
//   scl    out   I2C clock, push-pull, idle high
//   sda    inout I2C data, open-drain (drives 0 or z only)
module i2c_eeprom_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter logic [3:0]  DEV_ID  = 4'b1010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr,
    input  logic        rd,
    input  logic [10:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl,
    inout  wire         sda
);

    localparam int unsigned   CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QCNT_MAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, CTRL_W, ADDR, WDATA, RSTART, CTRL_R, RDATA, MACK, STOP, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [3:0]    bit_q, bit_d;
    logic          op_rd_q, op_rd_d;
    logic [10:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          nack_q, nack_d;

    logic          sda_low;
    logic [7:0]    tx_byte;
    logic          quarter_end;
    logic          slot_end;
    logic          sample_pt;
    logic          scl_mid;
    logic          tx_state;

    // Timing strobes: sampling happens on the last clock of Q2, state moves on
    // the last clock of Q3.
    assign quarter_end = (qcnt_q == QCNT_MAX);
    assign slot_end    = quarter_end && (quarter_q == 2'd3);
    assign sample_pt   = quarter_end && (quarter_q == 2'd2);
    assign scl_mid     = (quarter_q == 2'd1) || (quarter_q == 2'd2);
    assign tx_state    = (state_q == CTRL_W) || (state_q == ADDR) ||
                         (state_q == WDATA)  || (state_q == CTRL_R);

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 4'd0;
            op_rd_q   <= 1'b0;
            addr_q    <= 11'd0;
            wdata_q   <= 8'd0;
            rx_q      <= 8'd0;
            rdata_q   <= 8'd0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            op_rd_q   <= op_rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            nack_q    <= nack_d;
        end
    end

    // Next-state logic: request capture, quarter/slot timing, bit counting,
    // ACK and read-data sampling, and the byte sequencing.
    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        op_rd_d   = op_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;

        case (state_q)
            IDLE: begin
                if (wr || rd) begin
                    state_d = START;
                    op_rd_d = !wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                    nack_d  = 1'b0;
                end
            end
            FIN: state_d = IDLE;
            default: begin
                if (quarter_end) begin
                    qcnt_d    = '0;
                    quarter_d = quarter_q + 2'd1;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end

                // The 9th slot of a transmitted byte is the slave's ACK;
                // a released (high) line there means NACK.
                if (sample_pt) begin
                    if (tx_state && (bit_q == 4'd8)) begin
                        nack_d = sda;
                    end
                    if (state_q == RDATA) begin
                        rx_d = {rx_q[6:0], sda};
                    end
                end

                if (slot_end) begin
                    bit_d = 4'd0;
                    case (state_q)
                        START:  state_d = CTRL_W;
                        RSTART: state_d = CTRL_R;
                        CTRL_W, ADDR, WDATA, CTRL_R: begin
                            if (bit_q != 4'd8) begin
                                bit_d = bit_q + 4'd1;
                            end else if (nack_q) begin
                                state_d = STOP;
                            end else begin
                                case (state_q)
                                    CTRL_W:  state_d = ADDR;
                                    ADDR:    state_d = op_rd_q ? RSTART : WDATA;
                                    WDATA:   state_d = STOP;
                                    default: state_d = RDATA;
                                endcase
                            end
                        end
                        RDATA: begin
                            if (bit_q == 4'd7) begin
                                state_d = MACK;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                        MACK: state_d = STOP;
                        STOP: begin
                            state_d = FIN;
                            if (op_rd_q && !nack_q) begin
                                rdata_d = rx_q;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    // Output logic: SCL waveform and SDA pull-down per state and quarter.
    // START/RSTART pull SDA low in Q2 while SCL is high; STOP releases SDA in
    // Q2 while SCL is held high through the end of the slot.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;

        case (state_q)
            CTRL_W:  tx_byte = {DEV_ID, addr_q[10:8], 1'b0};
            ADDR:    tx_byte = addr_q[7:0];
            WDATA:   tx_byte = wdata_q;
            CTRL_R:  tx_byte = {DEV_ID, addr_q[10:8], 1'b1};
            default: tx_byte = 8'd0;
        endcase

        case (state_q)
            IDLE: busy = 1'b0;
            FIN: begin
                busy = 1'b0;
                done = 1'b1;
            end
            START, RSTART: begin
                scl     = scl_mid;
                sda_low = quarter_q[1];
            end
            STOP: begin
                scl     = (quarter_q != 2'd0);
                sda_low = !quarter_q[1];
            end
            CTRL_W, ADDR, WDATA, CTRL_R: begin
                scl     = scl_mid;
                sda_low = !bit_q[3] && !tx_byte[3'd7 - bit_q[2:0]];
            end
            default: scl = scl_mid;
        endcase
    end

    assign sda   = sda_low ? 1'b0 : 1'bz;
    assign rdata = rdata_q;
    assign nack  = nack_q;

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// tb_i2c_eeprom_master
// Randomised, scoreboard-checked bench for i2c_eeprom_master. A behavioural
// EEPROM slave watches the bus at transaction level (START/STOP, bytes, ACKs)
// and reports every bus token it sees; the reference model predicts the token
// stream, the done latency, nack and rdata from the protocol rules.
module tb_i2c_eeprom_master;

    localparam int CD      = 3;
    localparam int TOK_S   = 256;
    localparam int TOK_P   = 512;
    localparam int TOK_MNK = 768;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [10:0] addr = 11'd0;
    logic [7:0]  wdata = 8'd0;
    wire  [7:0]  rdata;
    wire         busy;
    wire         done;
    wire         nack;
    wire         scl;
    wire         sda_bus;

    pullup (sda_bus);

    i2c_eeprom_master #(.CLK_DIV(CD), .DEV_ID(4'b1010)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .rd    (rd),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .nack  (nack),
        .scl   (scl),
        .sda   (sda_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         nack;
        logic [7:0] rdata;
        int         lat;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    int         exp_bus[$];
    exp_t       mon_e;
    int         done_count = 0;
    int         exp_done_count = 0;
    logic [7:0] ref_mem[2048];
    logic [7:0] model_rdata = 8'd0;
    bit         slave_connected = 1'b1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // ---------------- behavioural EEPROM slave ----------------
    logic [7:0]  sl_mem[2048];
    logic        sl_drive = 1'b0;
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;
    bit          sl_active = 1'b0;
    bit          sl_rx = 1'b0;
    bit          sl_tx = 1'b0;
    bit          sl_pend_tx = 1'b0;
    int          sl_bcnt = 0;
    int          sl_byte_idx = 0;
    logic [7:0]  sl_sh = 8'd0;
    logic [7:0]  sl_txb = 8'd0;
    logic [10:0] sl_ptr = 11'd0;

    assign sda_bus = sl_drive ? 1'b0 : 1'bz;

    task automatic logToken(input int tok);
        if (exp_bus.size() == 0) checkOutput("bus_extra", tok, -1);
        else checkOutput("bus_token", tok, exp_bus.pop_front());
    endtask

    always @(negedge clk) begin
        if (scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b1 && sda_bus === 1'b0) begin
            logToken(TOK_S);
            sl_active = 1'b1; sl_rx = 1'b1; sl_tx = 1'b0; sl_pend_tx = 1'b0;
            sl_bcnt = 0; sl_byte_idx = 0; sl_drive = 1'b0;
        end else if (scl === 1'b1 && p_scl === 1'b1 && p_sda === 1'b0 && sda_bus === 1'b1) begin
            logToken(TOK_P);
            sl_active = 1'b0; sl_rx = 1'b0; sl_tx = 1'b0; sl_drive = 1'b0;
        end else if (sl_active && p_scl === 1'b0 && scl === 1'b1) begin
            if (sl_bcnt < 8) begin
                sl_sh = {sl_sh[6:0], sda_bus === 1'b1};
            end else if (sl_bcnt == 8 && sl_tx && sda_bus === 1'b1) begin
                logToken(TOK_MNK);
                sl_tx = 1'b0;
            end
            if (sl_bcnt < 9) sl_bcnt++;
        end else if (sl_active && p_scl === 1'b1 && scl === 1'b0) begin
            if (sl_bcnt == 8) begin
                if (sl_rx) begin
                    logToken(int'(sl_sh));
                    if (sl_byte_idx == 0) begin
                        if (sl_sh[0]) begin
                            sl_pend_tx = 1'b1;
                            sl_txb = sl_mem[sl_ptr];
                        end else begin
                            sl_ptr[10:8] = sl_sh[3:1];
                        end
                    end else if (sl_byte_idx == 1) begin
                        sl_ptr[7:0] = sl_sh;
                    end else begin
                        sl_mem[sl_ptr] = sl_sh;
                        sl_ptr = sl_ptr + 11'd1;
                    end
                    sl_byte_idx++;
                    sl_drive = slave_connected;
                end else begin
                    sl_drive = 1'b0;
                end
            end else if (sl_bcnt == 9) begin
                sl_drive = 1'b0;
                sl_bcnt = 0;
                if (sl_pend_tx && slave_connected) begin
                    sl_pend_tx = 1'b0; sl_rx = 1'b0; sl_tx = 1'b1;
                    sl_drive = !sl_txb[7];
                end
            end else if (sl_tx) begin
                sl_drive = !sl_txb[7 - sl_bcnt];
            end
        end
        p_scl = scl;
        p_sda = sda_bus;
    end

    // ---------------- monitor: pops the scoreboard on every done ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("nack", int'(nack), int'(mon_e.nack));
                checkOutput("rdata", int'(rdata), int'(mon_e.rdata));
                checkOutput("latency", cyc - mon_e.acc, mon_e.lat);
                checkOutput("busy_with_done", int'(busy), 0);
            end
        end
    end

    // Issue one request and record what the bus and the done pulse must show.
    // With abort set, the transaction will be killed by reset during ADDR.
    task automatic applyStimulus(input bit do_wr, input bit do_rd,
                                 input logic [10:0] a, input logic [7:0] d,
                                 input bit abort);
        exp_t       e;
        bit         is_write;
        logic [7:0] ctrl;
        for (int i = 0; i < 3000 && (busy || done); i++) @(negedge clk);
        wr = do_wr; rd = do_rd; addr = a; wdata = d;
        is_write = do_wr;
        ctrl = {4'b1010, a[10:8], 1'b0};
        e.nack = 1'b0;
        exp_bus.push_back(TOK_S);
        exp_bus.push_back(int'(ctrl));
        if (!abort) begin
            if (!slave_connected) begin
                exp_bus.push_back(TOK_P);
                e.nack = 1'b1;
                e.lat = 44 * CD;
            end else if (is_write) begin
                exp_bus.push_back(int'(a[7:0]));
                exp_bus.push_back(int'(d));
                exp_bus.push_back(TOK_P);
                ref_mem[a] = d;
                e.lat = 116 * CD;
            end else begin
                exp_bus.push_back(int'(a[7:0]));
                exp_bus.push_back(TOK_S);
                exp_bus.push_back(int'(ctrl | 8'h01));
                exp_bus.push_back(TOK_MNK);
                exp_bus.push_back(TOK_P);
                model_rdata = ref_mem[a];
                e.lat = 156 * CD;
            end
            e.rdata = model_rdata;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        checkOutput("busy_after_accept", int'(busy), 1);
        if (!abort) begin
            sb_q.push_back(e);
            exp_done_count++;
        end
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic waitDone();
        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(negedge clk);
        checkOutput("txn_timeout", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [10:0] a;
        logic [10:0] last_wr_a;
        for (int i = 0; i < 2048; i++) begin
            ref_mem[i] = 8'(i * 7 + 3);
            sl_mem[i]  = 8'(i * 7 + 3);
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_scl", int'(scl), 1);
        checkOutput("reset_sda", int'(sda_bus), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_nack", int'(nack), 0);
        checkOutput("reset_rdata", int'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read-back
        applyStimulus(1'b1, 1'b0, 11'h123, 8'h5A, 1'b0);
        waitDone();
        applyStimulus(1'b0, 1'b1, 11'h123, 8'h00, 1'b0);
        waitDone();

        // Top of the address space
        applyStimulus(1'b1, 1'b0, 11'h7FF, 8'hC3, 1'b0);
        waitDone();
        applyStimulus(1'b0, 1'b1, 11'h7FF, 8'h00, 1'b0);
        waitDone();

        // Slave disconnected: NACK on the control byte
        slave_connected = 1'b0;
        applyStimulus(1'b1, 1'b0, 11'h055, 8'h99, 1'b0);
        waitDone();
        slave_connected = 1'b1;

        // wr and rd together, then rd while busy
        applyStimulus(1'b1, 1'b1, 11'h2A4, 8'h3C, 1'b0);
        repeat (5) @(negedge clk);
        rd = 1'b1;
        addr = 11'h100;
        checkOutput("busy_at_ignored_rd", int'(busy), 1);
        @(negedge clk);
        rd = 1'b0;
        waitDone();
        repeat (300) @(negedge clk);
        checkOutput("no_second_txn", done_count, exp_done_count);

        // Randomised traffic
        last_wr_a = 11'h123;
        for (int i = 0; i < 10; i++) begin
            a = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, 1'b0, a, 8'($urandom), 1'b0);
                last_wr_a = a;
            end else begin
                if (i % 2 == 1) a = last_wr_a;
                applyStimulus(1'b0, 1'b1, a, 8'h00, 1'b0);
            end
            waitDone();
        end

        // Reset in the middle of the ADDR byte
        applyStimulus(1'b1, 1'b0, 11'h234, 8'h11, 1'b1);
        for (int i = 0; i < 2000 && !(sl_byte_idx == 1 && sl_bcnt == 3); i++) @(negedge clk);
        checkOutput("reached_addr_byte", sl_byte_idx * 16 + sl_bcnt, 16 + 3);
        for (int i = 0; i < 100 && scl !== 1'b0; i++) @(negedge clk);
        rst_n = 1'b0;
        model_rdata = 8'd0;
        #1;
        checkOutput("midreset_scl", int'(scl), 1);
        checkOutput("midreset_sda", int'(sda_bus), 1);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_rdata", int'(rdata), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 11'h234, 8'h00, 1'b0);
        waitDone();

        repeat (50) @(negedge clk);
        checkOutput("done_count", done_count, exp_done_count);
        checkOutput("bus_tokens_left", exp_bus.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_eeprom_master.md
I2C_EEPROM_MASTER -- requirements
Module: i2c_eeprom_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-bit; legal range 2..1023.
REQ-002 SHALL have parameter DEV_ID, default 4'b1010: fixed upper nibble of every control byte.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have the following ports:
  clk    in     1   system clock, all state on rising edge
  rst_n  in     1   asynchronous active-low reset
  wr     in     1   single-byte write request, sampled in IDLE
  rd     in     1   single-byte random-read request, sampled in IDLE
  addr   in     11  byte address into the 2048-byte EEPROM
  wdata  in     8   write data, captured on accept
  rdata  out    8   last byte read
  busy   out    1   high from the accept cycle until done
  done   out    1   one-cycle pulse at end of transaction
  nack   out    1   valid with done; 1 = slave did not acknowledge
  scl    out    1   I2C clock, push-pull, idle high
  sda    inout  1   I2C data, open-drain: drive 0 or z, never 1

Function
REQ-005 SHALL accept a request only when busy=0; it SHALL latch addr, wdata and the operation type on the accepting edge.
REQ-006 SHALL give wr priority when wr and rd are both high in the same cycle, and SHALL ignore requests while busy=1.
REQ-007 SHALL divide each bit slot into 4 quarters of CLK_DIV cycles: Q0 SCL low with SDA updated, Q1 SCL rising, Q2 SCL high with SDA sampled, Q3 SCL falling.
REQ-008 SHALL produce START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high; each SHALL occupy one slot.
REQ-009 SHALL build the control byte as {DEV_ID, addr[10:8], R/W}, with R/W=0 for write and R/W=1 for read, and SHALL send the address byte as addr[7:0]; all bytes MSB first.
REQ-010 SHALL use the FSM states IDLE, START, CTRL_W, ADDR, WDATA, RSTART, CTRL_R, RDATA, MACK, STOP, FIN.
REQ-011 SHALL sequence a write as IDLE, START, CTRL_W, ADDR, WDATA, STOP, FIN, IDLE.
REQ-012 SHALL sequence a read as IDLE, START, CTRL_W, ADDR, RSTART, CTRL_R, RDATA, MACK, STOP, FIN, IDLE.
REQ-013 SHALL make every byte state 9 slots long: 8 data bits plus the 9th (ACK) slot, during which the master releases sda (z) and samples it in Q2.
REQ-014 SHALL abort on NACK: if sda=1 in an ACK Q2, the FSM goes directly to STOP, and done is pulsed with nack=1.
REQ-015 SHALL shift one sda bit per RDATA slot in Q2 and SHALL update rdata only at FIN of a successful read; rdata SHALL be unchanged on nack or write.
REQ-016 SHALL leave sda released (z) in MACK so the master NACKs the byte, ending the read.
REQ-017 SHALL pulse done for exactly one cycle 116*CLK_DIV cycles after the accepting edge for a write (29 slots) and 156*CLK_DIV cycles after it for a read (39 slots); busy SHALL fall in the same cycle as done.
REQ-018 SHALL keep scl=1 and sda=z in IDLE and FIN.
REQ-019 SHALL use an internal quarter counter that wraps 0..CLK_DIV-1 and a bit counter that wraps 0..8, with no other width truncation.

Reset
REQ-020 SHALL force, on rst_n low, asynchronously: FSM=IDLE, scl=1, sda=z, busy=0, done=0, nack=0, rdata=8'h00, all counters 0.
REQ-021 SHALL abandon any transaction in progress when reset occurs mid-transaction, without generating a STOP, and SHALL accept a new request on the first edge after rst_n rises.

Verification
REQ-022 SHALL be covered by a write scenario: wr, addr=11'h123, wdata=8'h5A -> bus bytes A2,23,5A all ACKed, STOP; model memory[0x123]=5A; done after 116*CLK_DIV cycles, nack=0.
REQ-023 SHALL be covered by a read-back scenario: rd, addr=11'h123 -> bytes A2,23, repeated START, A3, master NACK, STOP; rdata=5A, done after 156*CLK_DIV cycles.
REQ-024 SHALL be covered by a boundary-address scenario: wr addr=11'h7FF wdata=8'hC3, then rd addr=11'h7FF -> control bytes AE/AF, rdata=C3.
REQ-025 SHALL be covered by a NACK scenario: slave disconnected (pull-up only), wr -> nack=1 at done, STOP seen right after the first ACK slot, rdata unchanged.
REQ-026 SHALL be covered by a request-conflict scenario: wr and rd high in the same cycle -> write executed; rd pulsed while busy -> ignored, no second transaction.
REQ-027 SHALL be covered by a mid-transaction reset scenario: rst_n low during the ADDR byte -> same cycle scl=1, sda=z, busy=0; a following rd completes normally.
